neural_frame_packer: RTL and testbench
======================================

# neural_frame_packer

Parametrised successor to the fixed 16→32-bit neural data path between the Intan SPI engine and the Xillybus `neural_data_32` read stream. It frames raw 16-bit samples from the SPI engine into 32-bit words. Each frame gets a 64-bit magic header and a 32-bit frame index. Frames go into an internal FIFO sized by parameter. A frame that cannot fit whole is dropped whole, and the drop is counted, so the host never sees a torn frame.

## Interface
- `FRAME_WORDS`, default 280: 16-bit input words per frame; must be even and ≥2.
- `FIFO_DEPTH`, default 1024: 32-bit FIFO entries; power of 2; must be ≥ `FRAME_WORDS`/2+3.
- `MAGIC`, default 64'hC691_1999_2702_1942: header constant.
- `bus_clk`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous assert, active-low; release synchronous to `bus_clk` is the integrator's job.
- `enable`  in  1  frame admission enable, sampled only on a SOF word.
- `in_data`  in  16  sample word.
- `in_wen`  in  1  `in_data` valid. Contract: at most one assertion every 2 cycles.
- `in_sof`  in  1  qualifies the `in_wen` word as first of a frame.
- `rd_en`  in  1  read strobe from Xillybus.
- `rd_data`  out  32  FIFO read data.
- `rd_empty`  out  1  FIFO empty.
- `fill_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `drop_count`  out  16  dropped frames; saturates at 0xFFFF.
- `overflow`  out  1  sticky; set on any drop.
- `sync_error`  out  1  sticky; set on a framing violation.
- `clear_flags`  in  1  synchronous clear of `overflow`, `sync_error` and `drop_count`.

## Operation
- Out-frame length L = `FRAME_WORDS`/2 + 3 words:
  - HDR0 = `MAGIC`[31:0]
  - HDR1 = `MAGIC`[63:32]
  - IDX
  - payload pairs; the earlier sample goes in [15:0].
- `frame_index` is a 32-bit internal counter. It increments on every SOF accepted while `enable`=1, whether the frame is admitted or dropped, so host-visible gaps mark drops. IDX carries the value before the increment; the first frame after reset has IDX=0.
- FSM states: IDLE, HEADER, PAYLOAD, DROP.
- IDLE:
  - `in_wen` without SOF: discard the word and set `sync_error`.
  - SOF with `enable`=0: discard; no count change.
  - SOF with `enable`=1 and free space (`FIFO_DEPTH`−`fill_level`) ≥ L: admit; latch the word as the low half; go to HEADER.
  - SOF with `enable`=1 and free space < L: increment `drop_count` (saturating), set `overflow`, go to DROP.
- HEADER: write HDR0, HDR1, IDX on 3 consecutive cycles, then go to PAYLOAD. Payload words arriving meanwhile are still collected.
- PAYLOAD:
  - Every second word completes a pair into a 1-entry pending register.
  - The write port drains the pending register whenever it is not writing a header.
  - After word `FRAME_WORDS` is received and the pending register has drained, return to IDLE.
  - `in_sof` seen in PAYLOAD is treated as an ordinary word and sets `sync_error`.
- DROP: discard words until the next SOF, which is then evaluated exactly as in IDLE.
- Admitted frames always fit, because reads only ever add free space.
- `enable` falling mid-frame does not truncate the frame.
- `rd_en` while empty is ignored. FIFO pointers wrap modulo `FIFO_DEPTH`.
- `clear_flags` coinciding with a drop: the drop wins (`overflow`=1, `drop_count`=1).

## Timing
- `rd_data` is valid 1 cycle after `rd_en` with `rd_empty`=0. This is a registered read, not fall-through.
- HDR0 is written in the cycle after SOF acceptance; `rd_empty` falls 1 cycle after the first write.
- `fill_level` updates the cycle after the write or read. A simultaneous read and write leaves it unchanged.
- Reset values: `rd_data`=0, `rd_empty`=1, `fill_level`=0, `drop_count`=0, `overflow`=0, `sync_error`=0; FSM=IDLE; `frame_index`=0; pending register empty.
- Reset mid-frame discards the FIFO contents and the partial frame.

## Structure
- Package `neural_pkg`: `MAGIC` default, FSM state enum, and the L-computation function.
- Sub-module `sync_fifo_32`: the registered-read FIFO with level output.
- The packer FSM, pending register and counters live in the top module.

## Test plan
All tests use `FRAME_WORDS`=4, `FIFO_DEPTH`=16, so L=5.
- Single frame: SOF with words 0x1111, 0x2222, 0x3333, 0x4444 → reads give 0x27021942, 0xC6911999, 0x00000000, 0x22221111, 0x44443333; `rd_empty`=1 afterwards.
- Overflow: 4 frames with no reads → `fill_level`=15; frame 4 is dropped, `drop_count`=1, `overflow`=1. Read 5 words, then send frame 5 → it is admitted with IDX=4.
- Sync errors:
  - A 5th word without SOF → discarded, `sync_error`=1, `fill_level` unchanged.
  - SOF at word 3 of a frame → frame completes with 4 payload words, `sync_error`=1.
- FIFO edges:
  - `rd_en` held on an empty FIFO → no level change, `rd_data` stable.
  - Read concurrent with a payload write → `fill_level` constant.
- Enable and clear:
  - `enable`=0 at SOF → nothing written, next admitted IDX=0.
  - `clear_flags` pulse → `overflow`=0, `sync_error`=0, `drop_count`=0.
- Reset: assert `reset_n` after HDR1 has been written → all outputs at reset values immediately; the next frame's IDX=0.

Source files
------------

// File: rtl/neural_frame_packer_pkg.sv
// Shared constants, FSM state encoding and frame-length helper for the
// neural frame packer slice.
package neural_pkg;
   localparam int unsigned IN_W  = 16;
   localparam int unsigned OUT_W = 32;
   localparam logic [63:0] MAGIC_DEFAULT = 64'hC691_1999_2702_1942;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } state_e;

   // Output words per frame: two magic words, the index, then sample pairs.
   function automatic int unsigned frame_len(input int unsigned frame_words);
      return frame_words / 2 + 3;
   endfunction
endpackage

// File: rtl/neural_frame_packer_if.sv
// Sample-input, read-stream and status bundle between the SPI engine side,
// the packer and the host read port.
interface neural_frame_packer_if
   import neural_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 1024
);
   logic                        enable;
   logic [IN_W-1:0]             in_data;
   logic                        in_wen;
   logic                        in_sof;
   logic                        rd_en;
   logic [OUT_W-1:0]            rd_data;
   logic                        rd_empty;
   logic [$clog2(FIFO_DEPTH):0] fill_level;
   logic [15:0]                 drop_count;
   logic                        overflow;
   logic                        sync_error;
   logic                        clear_flags;

   modport master (
      output enable, in_data, in_wen, in_sof, rd_en, clear_flags,
      input  rd_data, rd_empty, fill_level, drop_count, overflow, sync_error
   );

   modport slave (
      input  enable, in_data, in_wen, in_sof, rd_en, clear_flags,
      output rd_data, rd_empty, fill_level, drop_count, overflow, sync_error
   );
endinterface

// File: rtl/neural_frame_packer_fifo.sv
// 32-bit synchronous FIFO with registered read data and an occupancy count.
module sync_fifo_32
   import neural_pkg::*;
#(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [OUT_W-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [OUT_W-1:0]       rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (level == '0);
   assign do_rd = rd_en && !empty;
   // A full FIFO still accepts a write when the same cycle frees a slot.
   assign do_wr = wr_en && ((level != (AW + 1)'(DEPTH)) || do_rd);

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         level   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) begin
            rptr    <= rptr + 1'b1;
            rd_data <= mem[rptr];
         end
         case ({do_wr, do_rd})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/neural_frame_packer.sv
// Frames 16-bit SPI samples into 32-bit words behind a magic header and frame
// index; frames that cannot fit whole are dropped whole and counted.
module neural_frame_packer
   import neural_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = 280,
   parameter int unsigned FIFO_DEPTH  = 1024,
   parameter logic [63:0] MAGIC       = MAGIC_DEFAULT
) (
   input  logic                 bus_clk,
   input  logic                 reset_n,
   neural_frame_packer_if.slave bus
);
   localparam int unsigned L   = frame_len(FRAME_WORDS);
   localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);

   localparam logic [1:0] S_IDLE    = ST_IDLE;
   localparam logic [1:0] S_HEADER  = ST_HEADER;
   localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;
   localparam logic [1:0] S_DROP    = ST_DROP;

   logic [1:0]       state;
   logic [1:0]       hcnt;
   logic [WCW-1:0]   wcnt;
   logic [IN_W-1:0]  low_half;
   logic [OUT_W-1:0] pending;
   logic             pending_valid;
   logic [31:0]      frame_index;
   logic [31:0]      idx_latch;
   logic [15:0]      drop_count;
   logic             overflow;
   logic             sync_error;

   logic             wr_en;
   logic [OUT_W-1:0] wr_data;
   logic [LW-1:0]    level;

   logic sof, in_frame, sof_on, room, admit, drop_hit, frame_word, sync_hit, drain;

   assign sof        = bus.in_wen && bus.in_sof;
   assign in_frame   = (state == S_HEADER) || (state == S_PAYLOAD);
   assign sof_on     = sof && bus.enable && !in_frame;
   assign room       = (LW'(FIFO_DEPTH) - level) >= LW'(L);
   assign admit      = sof_on && room;
   assign drop_hit   = sof_on && !room;
   assign frame_word = bus.in_wen && in_frame && (wcnt != WCW'(FRAME_WORDS));
   assign sync_hit   = bus.in_wen && (((state == S_IDLE) && !bus.in_sof) ||
                                      (in_frame && bus.in_sof));
   assign drain      = (state == S_PAYLOAD) && pending_valid;

   // Headers own the write port; completed pairs wait in pending until PAYLOAD.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = pending;
      if (state == S_HEADER) begin
         wr_en = 1'b1;
         case (hcnt)
            2'd0:    wr_data = MAGIC[31:0];
            2'd1:    wr_data = MAGIC[63:32];
            default: wr_data = idx_latch;
         endcase
      end else if (drain) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         hcnt          <= '0;
         wcnt          <= '0;
         low_half      <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         frame_index   <= '0;
         idx_latch     <= '0;
      end else begin
         case (state)
            S_IDLE, S_DROP: begin
               if (admit) begin
                  state     <= S_HEADER;
                  hcnt      <= '0;
                  wcnt      <= WCW'(1);
                  low_half  <= bus.in_data;
                  idx_latch <= frame_index;
               end else if (sof) begin
                  state <= S_DROP;
               end
            end
            S_HEADER: begin
               hcnt <= hcnt + 2'd1;
               if (hcnt == 2'd2) state <= S_PAYLOAD;
            end
            S_PAYLOAD: begin
               if (drain && (wcnt == WCW'(FRAME_WORDS))) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (sof_on) frame_index <= frame_index + 32'd1;

         if (frame_word) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt[0]) pending  <= {bus.in_data, low_half};
            else         low_half <= bus.in_data;
         end

         if (frame_word && wcnt[0]) pending_valid <= 1'b1;
         else if (drain)            pending_valid <= 1'b0;
      end
   end

   // A drop in the same cycle as clear_flags leaves a fresh count of one.
   always_ff @(posedge bus_clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
         overflow   <= 1'b0;
         sync_error <= 1'b0;
      end else begin
         if (drop_hit) begin
            overflow <= 1'b1;
            if (bus.clear_flags)              drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end else if (bus.clear_flags) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end

         if (sync_hit)             sync_error <= 1'b1;
         else if (bus.clear_flags) sync_error <= 1'b0;
      end
   end

   sync_fifo_32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (bus_clk),
      .rst_n   (reset_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (bus.rd_en),
      .rd_data (bus.rd_data),
      .empty   (bus.rd_empty),
      .level   (level)
   );

   assign bus.fill_level = level;
   assign bus.drop_count = drop_count;
   assign bus.overflow   = overflow;
   assign bus.sync_error = sync_error;
endmodule

// File: tb/tb_neural_frame_packer.sv
// Self-checking bench for neural_frame_packer with FRAME_WORDS=4, FIFO_DEPTH=16.
module tb_neural_frame_packer;
   localparam int unsigned FW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned L     = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neural_frame_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

   neural_frame_packer #(
      .FRAME_WORDS (FW),
      .FIFO_DEPTH  (DEPTH),
      .MAGIC       (64'hC691_1999_2702_1942)
   ) dut (
      .bus_clk (clk),
      .reset_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic        en;
      logic [63:0] words;
      logic [4:0]  exp_fill;
      logic [15:0] exp_drop;
      logic        exp_ovf;
   } vec_t;

   // Reference model: queue of host-visible words plus frame-level status.
   logic [31:0] q[$];
   logic [63:0] magic;
   logic [31:0] m_idx;
   logic [15:0] m_drop;
   logic        m_ovf, m_sync, m_discard;
   logic [31:0] m_last_rd;
   logic        clr_with_sof, rand_gap;
   logic [4:0]  fill_at_rd;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
   endtask

   task automatic check_status(input string tag);
      check({tag, ".fill"},  32'(bus.fill_level), 32'(q.size()));
      check({tag, ".empty"}, 32'(bus.rd_empty),   32'(q.size() == 0));
      check({tag, ".drop"},  32'(bus.drop_count), 32'(m_drop));
      check({tag, ".ovf"},   32'(bus.overflow),   32'(m_ovf));
      check({tag, ".sync"},  32'(bus.sync_error), 32'(m_sync));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".rd_data"}, bus.rd_data,             32'd0);
      check({tag, ".empty"},   32'(bus.rd_empty),       32'd1);
      check({tag, ".fill"},    32'(bus.fill_level),     32'd0);
      check({tag, ".drop"},    32'(bus.drop_count),     32'd0);
      check({tag, ".ovf"},     32'(bus.overflow),       32'd0);
      check({tag, ".sync"},    32'(bus.sync_error),     32'd0);
   endtask

   task automatic model_reset();
      q.delete();
      m_idx = '0; m_drop = '0; m_ovf = 1'b0; m_sync = 1'b0;
      m_discard = 1'b0; m_last_rd = '0;
   endtask

   task automatic model_sof(input logic en, input logic [63:0] w);
      if (clr_with_sof) begin m_drop = '0; m_ovf = 1'b0; m_sync = 1'b0; end
      if (!en) begin
         m_discard = 1'b1;
      end else begin
         if (DEPTH - q.size() >= L) begin
            q.push_back(magic[31:0]);
            q.push_back(magic[63:32]);
            q.push_back(m_idx);
            q.push_back(w[31:0]);
            q.push_back(w[63:32]);
            m_discard = 1'b0;
         end else begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_ovf = 1'b1;
            m_discard = 1'b1;
         end
         m_idx = m_idx + 32'd1;
      end
   endtask

   // Words go out every other cycle; rd_word pulses rd_en alongside that word.
   task automatic send_frame(input logic en, input logic [63:0] w, input int sof_pos, input int rd_word);
      logic [31:0] exp_rd;
      bus.enable = en;
      model_sof(en, w);
      if (sof_pos > 0 && !m_discard) m_sync = 1'b1;
      for (int i = 0; i < int'(FW); i++) begin
         bus.in_wen      = 1'b1;
         bus.in_sof      = (i == 0) || (i == sof_pos);
         bus.in_data     = w[16*i +: 16];
         bus.clear_flags = (i == 0) && clr_with_sof;
         bus.rd_en       = (i == rd_word);
         tick();
         bus.in_wen = 1'b0; bus.in_sof = 1'b0; bus.clear_flags = 1'b0; bus.rd_en = 1'b0;
         if (i == rd_word) begin
            exp_rd = q.pop_front();
            m_last_rd = exp_rd;
            check("concurrent_rd.data", bus.rd_data, exp_rd);
            fill_at_rd = bus.fill_level;
         end
         tick();
         if (rand_gap) repeat ($urandom_range(0, 2)) tick();
      end
      repeat (3) tick();
      clr_with_sof = 1'b0;
   endtask

   task automatic read_word(input string name, output logic [31:0] got);
      logic [31:0] exp;
      check({name, ".empty"}, 32'(bus.rd_empty), 32'(q.size() == 0));
      if (q.size() > 0) exp = q.pop_front();
      else              exp = m_last_rd;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      got = bus.rd_data;
      check({name, ".data"}, got, exp);
      m_last_rd = exp;
   endtask

   task automatic stray_word();
      bus.in_wen = 1'b1; bus.in_sof = 1'b0; bus.in_data = 16'hBEEF;
      tick();
      bus.in_wen = 1'b0;
      tick();
      if (!m_discard) m_sync = 1'b1;
   endtask

   task automatic pulse_clear();
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      tick();
      m_drop = '0; m_ovf = 1'b0; m_sync = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   initial begin
      vec_t        vt[5];
      logic [31:0] single_exp[5];
      logic [31:0] got;
      int          r;

      magic = 64'hC691_1999_2702_1942;
      bus.enable = 1'b0; bus.in_data = '0; bus.in_wen = 1'b0; bus.in_sof = 1'b0;
      bus.rd_en = 1'b0; bus.clear_flags = 1'b0;
      clr_with_sof = 1'b0; rand_gap = 1'b0; fill_at_rd = '0;
      model_reset();

      vt[0] = '{1'b0, 64'hA003_A002_A001_A000, 5'd0,  16'd0, 1'b0};
      vt[1] = '{1'b1, 64'hB003_B002_B001_B000, 5'd5,  16'd0, 1'b0};
      vt[2] = '{1'b1, 64'hC003_C002_C001_C000, 5'd10, 16'd0, 1'b0};
      vt[3] = '{1'b1, 64'hD003_D002_D001_D000, 5'd15, 16'd0, 1'b0};
      vt[4] = '{1'b1, 64'hE003_E002_E001_E000, 5'd15, 16'd1, 1'b1};
      single_exp = '{32'h2702_1942, 32'hC691_1999, 32'h0000_0000, 32'h2222_1111, 32'h4444_3333};

      repeat (3) tick();
      check_reset_values("reset");
      rst_n = 1'b1;
      tick();

      // Single frame with explicit header/empty timing
      model_sof(1'b1, 64'h4444_3333_2222_1111);
      bus.enable = 1'b1; bus.in_wen = 1'b1; bus.in_sof = 1'b1; bus.in_data = 16'h1111;
      tick();
      bus.in_wen = 1'b0; bus.in_sof = 1'b0;
      check("sof.empty", 32'(bus.rd_empty), 32'd1);
      tick();
      check("hdr0.empty", 32'(bus.rd_empty), 32'd0);
      check("hdr0.fill", 32'(bus.fill_level), 32'd1);
      for (int i = 1; i < 4; i++) begin
         bus.in_wen = 1'b1;
         bus.in_data = (i == 1) ? 16'h2222 : ((i == 2) ? 16'h3333 : 16'h4444);
         tick();
         bus.in_wen = 1'b0;
         tick();
      end
      repeat (3) tick();
      for (int k = 0; k < 5; k++) begin
         bus.rd_en = 1'b1;
         tick();
         bus.rd_en = 1'b0;
         void'(q.pop_front());
         m_last_rd = single_exp[k];
         check("single.data", bus.rd_data, single_exp[k]);
      end
      tick();
      check("single.empty_after", 32'(bus.rd_empty), 32'd1);

      // Table: disabled SOF, fill to 15, then a dropped frame
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_frame(vt[i].en, vt[i].words, -1, -1);
         check("table.fill", 32'(bus.fill_level), 32'(vt[i].exp_fill));
         check("table.drop", 32'(bus.drop_count), 32'(vt[i].exp_drop));
         check("table.ovf",  32'(bus.overflow),   32'(vt[i].exp_ovf));
      end
      for (int k = 0; k < 5; k++) begin
         read_word("table.rd", got);
         if (k == 2) check("table.idx_first", got, 32'd0);
      end
      send_frame(1'b1, 64'hF003_F002_F001_F000, -1, -1);
      check("after_drop.fill", 32'(bus.fill_level), 32'd15);
      for (int k = 0; k < 10; k++) read_word("drain.rd", got);
      for (int k = 0; k < 5; k++) begin
         read_word("after_drop.rd", got);
         if (k == 2) check("after_drop.idx", got, 32'd4);
      end
      check_status("drained");

      // Clear flags
      pulse_clear();
      check("clear.ovf",  32'(bus.overflow),   32'd0);
      check("clear.sync", 32'(bus.sync_error), 32'd0);
      check("clear.drop", 32'(bus.drop_count), 32'd0);

      // Sync errors: stray word, then SOF inside a frame
      stray_word();
      check("stray.sync", 32'(bus.sync_error), 32'd1);
      check_status("stray");
      pulse_clear();
      send_frame(1'b1, 64'h1004_1003_1002_1001, 2, -1);
      check("mid_sof.sync", 32'(bus.sync_error), 32'd1);
      check("mid_sof.fill", 32'(bus.fill_level), 32'd5);
      for (int k = 0; k < 5; k++) read_word("mid_sof.rd", got);

      // rd_en held on an empty FIFO
      bus.rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("empty_rd.fill", 32'(bus.fill_level), 32'd0);
         check("empty_rd.data", bus.rd_data, m_last_rd);
      end
      bus.rd_en = 1'b0;
      tick();

      // Read concurrent with the first payload write
      send_frame(1'b1, 64'h2004_2003_2002_2001, -1, -1);
      send_frame(1'b1, 64'h3004_3003_3002_3001, -1, 2);
      check("concurrent_rd.fill", 32'(fill_at_rd), 32'd8);
      check_status("concurrent");
      while (q.size() > 0) read_word("concurrent.rd", got);

      // clear_flags coinciding with a drop
      for (int i = 0; i < 3; i++) send_frame(1'b1, {$urandom(), $urandom()}, -1, -1);
      stray_word();
      send_frame(1'b1, 64'h5004_5003_5002_5001, -1, -1);
      clr_with_sof = 1'b1;
      send_frame(1'b1, 64'h6004_6003_6002_6001, -1, -1);
      check("clr_drop.drop", 32'(bus.drop_count), 32'd1);
      check("clr_drop.ovf",  32'(bus.overflow),   32'd1);
      check("clr_drop.sync", 32'(bus.sync_error), 32'd0);
      check_status("clr_drop");

      // Reset after HDR1 has been written
      bus.enable = 1'b1; bus.in_wen = 1'b1; bus.in_sof = 1'b1; bus.in_data = 16'h7001;
      tick();
      bus.in_wen = 1'b0; bus.in_sof = 1'b0;
      tick();
      bus.in_wen = 1'b1; bus.in_data = 16'h7002;
      tick();
      bus.in_wen = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(1'b1, 64'h8004_8003_8002_8001, -1, -1);
      for (int k = 0; k < 5; k++) begin
         read_word("post_reset.rd", got);
         if (k == 2) check("post_reset.idx", got, 32'd0);
      end

      // Randomised traffic against the model
      rand_gap = 1'b1;
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      send_frame($urandom_range(0, 5) != 0, {$urandom(), $urandom()}, -1, -1);
         else if (r <= 7) repeat ($urandom_range(1, 4)) read_word("rand.rd", got);
         else if (r == 8) stray_word();
         else             pulse_clear();
         check_status("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
